// File: rtl/pc_btb_unit.sv
// Fetch PC unit: reset vector, redirect/flush path, stall hold, and a direct-mapped
// BTB with 2-bit saturating counters used for next-PC prediction.
module pc_btb_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int unsigned       BTB_DEPTH  = 16,
  parameter int unsigned       INST_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_taken,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target
);

  localparam int unsigned OFS   = $clog2(INST_BYTES);
  localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
  localparam int unsigned TAG_W = ADDR_W - OFS - IDX_W;

  typedef enum logic {INIT, RUN} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;

  // Entry storage carries no reset so it can map onto RAM; the INIT sweep clears valid.
  logic              valid_q  [BTB_DEPTH];
  logic [TAG_W-1:0]  tag_q    [BTB_DEPTH];
  logic [ADDR_W-1:0] target_q [BTB_DEPTH];
  logic [1:0]        ctr_q    [BTB_DEPTH];

  logic [IDX_W-1:0]  fetch_idx, upd_idx, wr_idx;
  logic [TAG_W-1:0]  fetch_tag, upd_tag;
  logic              fetch_hit, upd_hit;
  logic              valid_we, valid_wd, tag_we, tgt_we, ctr_we;
  logic [1:0]        ctr_wd;

  assign fetch_idx = pc_q[OFS +: IDX_W];
  assign fetch_tag = pc_q[ADDR_W-1 -: TAG_W];
  assign upd_idx   = upd_pc[OFS +: IDX_W];
  assign upd_tag   = upd_pc[ADDR_W-1 -: TAG_W];

  always_comb begin
    fetch_hit   = (state_q == RUN) && valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
    pred_target = fetch_hit ? target_q[fetch_idx] : '0;
  end

  always_comb begin
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    wr_idx   = upd_idx;
    valid_we = 1'b0;
    valid_wd = 1'b0;
    tag_we   = 1'b0;
    tgt_we   = 1'b0;
    ctr_we   = 1'b0;
    ctr_wd   = 2'b10;
    if (state_q == INIT) begin
      wr_idx   = cnt_q;
      valid_we = 1'b1;
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_we = 1'b1;
        tgt_we = upd_taken;
        if (upd_taken) ctr_wd = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
        else           ctr_wd = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
      end else if (upd_taken) begin
        valid_we = 1'b1;
        valid_wd = 1'b1;
        tag_we   = 1'b1;
        tgt_we   = 1'b1;
        ctr_we   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (valid_we) valid_q[wr_idx]  <= valid_wd;
    if (tag_we)   tag_q[wr_idx]    <= upd_tag;
    if (tgt_we)   target_q[wr_idx] <= upd_target;
    if (ctr_we)   ctr_q[wr_idx]    <= ctr_wd;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    case (state_q)
      INIT: begin
        pc_d  = RESET_VEC;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(BTB_DEPTH - 1)) begin
          state_d    = RUN;
          pc_valid_d = 1'b1;
        end
      end
      RUN: begin
        pc_valid_d = 1'b1;
        if (redirect_valid)  pc_d = redirect_pc & ~ADDR_W'(INST_BYTES - 1);
        else if (stall)      pc_d = pc_q;
        else if (pred_taken) pc_d = pred_target;
        else                 pc_d = pc_q + ADDR_W'(INST_BYTES);
      end
      default: begin
        state_d    = INIT;
        cnt_d      = '0;
        pc_d       = RESET_VEC;
        pc_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;

endmodule

// File: tb/tb_pc_btb_unit.sv
// Self-checking bench for pc_btb_unit: directed scenarios plus random traffic,
// compared every cycle against an array-based behavioural model of the fetch unit.
module tb_pc_btb_unit;

  localparam int          AW    = 32;
  localparam logic [31:0] RV    = 32'h0040_0000;
  localparam int          DEPTH = 16;
  localparam int          IB    = 4;

  logic          clk;
  logic          reset_n;
  logic          stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          upd_valid;
  logic [AW-1:0] upd_pc;
  logic [AW-1:0] upd_target;
  logic          upd_taken;
  logic [AW-1:0] pc;
  logic          pc_valid;
  logic          pred_taken;
  logic [AW-1:0] pred_target;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  pc_btb_unit #(
    .ADDR_W(AW), .RESET_VEC(RV), .BTB_DEPTH(DEPTH), .INST_BYTES(IB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .pc(pc), .pc_valid(pc_valid), .pred_taken(pred_taken), .pred_target(pred_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: the BTB as plain arrays, time since reset release as a counter.
  logic [31:0] m_pc    = RV;
  int          m_edges = 0;
  bit          m_valid [DEPTH];
  logic [31:0] m_tag   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          m_ctr   [DEPTH];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'(IB)) % 32'(DEPTH));
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / 32'(IB * DEPTH);
  endfunction

  function automatic void model_predict(output bit t, output logic [31:0] tg);
    int i;
    i  = idx_of(m_pc);
    t  = 1'b0;
    tg = '0;
    if (m_edges >= DEPTH && m_valid[i] && m_tag[i] == tag_of(m_pc)) begin
      tg = m_tgt[i];
      t  = (m_ctr[i] >= 2);
    end
  endfunction

  function automatic void model_update();
    int i;
    i = idx_of(upd_pc);
    if (m_valid[i] && m_tag[i] == tag_of(upd_pc)) begin
      if (upd_taken) begin
        if (m_ctr[i] < 3) m_ctr[i] = m_ctr[i] + 1;
        m_tgt[i] = upd_target;
      end else if (m_ctr[i] > 0) begin
        m_ctr[i] = m_ctr[i] - 1;
      end
    end else if (upd_taken) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = tag_of(upd_pc);
      m_tgt[i]   = upd_target;
      m_ctr[i]   = 2;
    end
  endfunction

  initial begin
    bit          pt;
    logic [31:0] ptg, nxt;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_pc    = RV;
        m_edges = 0;
      end else if (m_edges < DEPTH) begin
        m_edges = m_edges + 1;
        if (m_edges == DEPTH)
          for (int k = 0; k < DEPTH; k++) m_valid[k] = 1'b0;
      end else begin
        model_predict(pt, ptg);
        if (redirect_valid) nxt = redirect_pc - (redirect_pc % 32'(IB));
        else if (stall)     nxt = m_pc;
        else if (pt)        nxt = ptg;
        else                nxt = m_pc + 32'(IB);
        if (upd_valid) model_update();
        m_pc = nxt;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    bit          pt;
    logic [31:0] ptg;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        model_predict(pt, ptg);
        checkOutput("model_pc", pc, m_pc);
        checkOutput("model_pc_valid", {31'b0, pc_valid}, {31'b0, (m_edges >= DEPTH)});
        checkOutput("model_pred_taken", {31'b0, pred_taken}, {31'b0, pt});
        checkOutput("model_pred_target", pred_target, ptg);
      end
    end
  end

  task automatic applyStimulus(input bit st, input bit rv, input logic [31:0] rpc,
                               input bit uv, input logic [31:0] upc,
                               input logic [31:0] utgt, input bit ut);
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_target     = utgt;
    upd_taken      = ut;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic redirectTo(input logic [31:0] a);
    applyStimulus(1'b0, 1'b1, a, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic update(input logic [31:0] a, input logic [31:0] t, input bit taken);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, a, t, taken);
  endtask

  task automatic pulseReset();
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_rst_pc", pc, RV);
    checkOutput("async_rst_valid", {31'b0, pc_valid}, 32'd0);
    checkOutput("async_rst_pred", {31'b0, pred_taken}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rpc, upc, utgt;
    reset_n        = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_target     = '0;
    upd_taken      = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    checkOutput("rst_pc", pc, RV);
    checkOutput("rst_valid", {31'b0, pc_valid}, 32'd0);

    reset_n = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      idle();
      checkOutput("init_valid", {31'b0, pc_valid}, 32'd0);
      checkOutput("init_pc", pc, RV);
    end
    idle();
    checkOutput("run_valid", {31'b0, pc_valid}, 32'd1);
    checkOutput("run_pc0", pc, 32'h0040_0000);
    idle();
    checkOutput("seq_pc1", pc, 32'h0040_0004);
    idle();
    checkOutput("seq_pc2", pc, 32'h0040_0008);

    repeat (3) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
      checkOutput("stall_hold", pc, 32'h0040_0008);
    end
    applyStimulus(1'b1, 1'b1, 32'h0040_0103, 1'b0, '0, '0, 1'b0);
    checkOutput("redirect_over_stall", pc, 32'h0040_0100);

    update(32'h0040_0010, 32'h0040_0080, 1'b1);
    redirectTo(32'h0040_0008);
    idle();
    idle();
    checkOutput("btb_hit_pc", pc, 32'h0040_0010);
    checkOutput("btb_pred_taken", {31'b0, pred_taken}, 32'd1);
    checkOutput("btb_pred_target", pred_target, 32'h0040_0080);
    idle();
    checkOutput("btb_follow", pc, 32'h0040_0080);

    update(32'h0040_0010, 32'h0, 1'b0);
    update(32'h0040_0010, 32'h0, 1'b0);
    redirectTo(32'h0040_0010);
    checkOutput("ctr0_not_taken", {31'b0, pred_taken}, 32'd0);
    idle();
    checkOutput("ctr0_seq", pc, 32'h0040_0014);

    redirectTo(32'h0040_0050);
    checkOutput("alias_miss", {31'b0, pred_taken}, 32'd0);
    checkOutput("alias_miss_tgt", pred_target, 32'h0);
    update(32'h0040_0050, 32'h0040_0200, 1'b1);
    redirectTo(32'h0040_0010);
    checkOutput("alias_evicted", {31'b0, pred_taken}, 32'd0);
    checkOutput("alias_evicted_tgt", pred_target, 32'h0);
    redirectTo(32'h0040_0050);
    checkOutput("alias_new_hit", {31'b0, pred_taken}, 32'd1);
    checkOutput("alias_new_tgt", pred_target, 32'h0040_0200);

    repeat (5) update(32'h0040_0050, 32'h0040_0200, 1'b1);
    update(32'h0040_0050, 32'h0, 1'b0);
    redirectTo(32'h0040_0050);
    checkOutput("sat_still_taken", {31'b0, pred_taken}, 32'd1);
    update(32'h0040_0050, 32'h0, 1'b0);
    redirectTo(32'h0040_0050);
    checkOutput("sat_weak_not_taken", {31'b0, pred_taken}, 32'd0);

    redirectTo(32'hFFFF_FFFC);
    checkOutput("wrap_pc", pc, 32'hFFFF_FFFC);
    checkOutput("wrap_no_pred", {31'b0, pred_taken}, 32'd0);
    idle();
    checkOutput("wrap_zero", pc, 32'h0);

    pulseReset();
    repeat (5) idle();
    pulseReset();
    for (int i = 1; i <= 15; i++) idle();
    checkOutput("resweep_valid_low", {31'b0, pc_valid}, 32'd0);
    idle();
    checkOutput("resweep_valid_high", {31'b0, pc_valid}, 32'd1);
    checkOutput("resweep_pc", pc, RV);

    for (int n = 0; n < 600; n++) begin
      rpc  = 32'h0040_0000 + 32'($urandom_range(0, 511));
      upc  = ($urandom_range(0, 3) == 0) ? m_pc : 32'h0040_0000 + 32'($urandom_range(0, 511));
      utgt = 32'h0040_0000 + 32'($urandom_range(0, 127)) * 32'd4;
      applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, rpc,
                    $urandom_range(0, 2) == 0, upc, utgt, $urandom_range(0, 2) != 0);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
